// File: rtl/seven_seg_pkg.sv
// Shared constants for the four-digit seven-segment display path:
// blank code, anode patterns, digit count and segment bit positions.
package seven_seg_pkg;

    localparam int unsigned DIGIT_COUNT = 4;

    typedef logic [7:0] seg_code_t;

    localparam seg_code_t BLANK_CODE = 8'hFF;

    // Segment bit positions, active-low, shared with the ASCII converters
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    typedef enum logic [1:0] {
        DIGIT_ONE,
        DIGIT_TWO,
        DIGIT_THREE,
        DIGIT_FOUR
    } digit_e;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // an[3] drives the leftmost digit
    localparam logic [3:0] ANODE_PATTERN [DIGIT_COUNT] = '{
        4'b0111,
        4'b1011,
        4'b1101,
        4'b1110
    };

endpackage

// File: rtl/refresh_prescaler.sv
// Slot divider for the display scan: cnt runs 0..REFRESH_DIV-1 and tick
// marks the last cycle of each slot.
module refresh_prescaler #(
    parameter int unsigned REFRESH_DIV = 50000,
    localparam int unsigned CNT_W      = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    always_comb begin
        tick = (cnt == CNT_W'(REFRESH_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed, double-buffered driver for a four-digit common-anode
// display. Optional PWM dimming is enabled with SEVSEG_BRIGHTNESS_EN.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
`ifdef SEVSEG_BRIGHTNESS_EN
    input  logic [3:0] brightness,
`endif
    input  logic [7:0] sevenSegOne,
    input  logic [7:0] sevenSegTwo,
    input  logic [7:0] sevenSegThree,
    input  logic [7:0] sevenSegFour,
    input  logic       update,
    output logic       busy,
    output logic       updateAck,
    output logic       frameStart,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt;
    logic             tick;

    seg_code_t inCodes [DIGIT_COUNT];
    seg_code_t pending [DIGIT_COUNT];
    seg_code_t display [DIGIT_COUNT];
    digit_e    idx;

    logic lastSlot;
    logic commitNow;
    logic wrapSeen;
    logic commitSeen;
    logic anActive;

    refresh_prescaler #(
        .REFRESH_DIV(REFRESH_DIV)
    ) prescaler (
        .clk  (clk),
        .reset(reset),
        .cnt  (cnt),
        .tick (tick)
    );

    always_comb begin
        inCodes[0] = sevenSegOne;
        inCodes[1] = sevenSegTwo;
        inCodes[2] = sevenSegThree;
        inCodes[3] = sevenSegFour;
        lastSlot   = tick && (idx == DIGIT_FOUR);
        // An update landing on the frame boundary commits directly
        commitNow  = lastSlot && (busy || update);
    end

`ifdef SEVSEG_BRIGHTNESS_EN
    localparam int unsigned SLOT_STEP = REFRESH_DIV / 16;

    logic [3:0] brightLevel;
    logic [3:0] slotBright;

    // The level used for a slot is the one present on its first cycle
    always_comb begin
        slotBright = (cnt == '0) ? brightness : brightLevel;
        anActive   = (32'(cnt) < ((32'(slotBright) + 32'd1) * SLOT_STEP));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            brightLevel <= 4'hF;
        end else if (cnt == '0) begin
            brightLevel <= brightness;
        end
    end
`else
    logic unusedCnt;

    assign unusedCnt = ^cnt;
    assign anActive  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '{default: BLANK_CODE};
            display    <= '{default: BLANK_CODE};
            busy       <= 1'b0;
            idx        <= DIGIT_ONE;
            seg        <= BLANK_CODE;
            an         <= ANODE_OFF;
            wrapSeen   <= 1'b0;
            commitSeen <= 1'b0;
            frameStart <= 1'b0;
            updateAck  <= 1'b0;
        end else begin
            if (update) begin
                pending <= inCodes;
            end

            if (commitNow) begin
                if (update) begin
                    display <= inCodes;
                end else begin
                    display <= pending;
                end
                busy <= 1'b0;
            end else if (update) begin
                busy <= 1'b1;
            end

            if (tick) begin
                idx <= digit_e'(idx + 2'd1);
            end

            seg <= display[idx];
            an  <= anActive ? ANODE_PATTERN[idx] : ANODE_OFF;

            // Pulses are delayed one cycle so they line up with an=0111
            wrapSeen   <= lastSlot;
            frameStart <= wrapSeen;
            commitSeen <= commitNow;
            updateAck  <= commitSeen;
        end
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for the Basys-2 four-digit common-anode display. It consumes the four 8-bit segment codes produced by the ASCII-to-segment converters and drives the physical cathode and anode pins. It cycles one digit per refresh slot and double-buffers the codes so updates take effect only at a frame boundary. It sits between the text/segment generation logic and the board pins.

## Interface
- REFRESH_DIV, 50000: clk cycles per digit slot (1 ms at 50 MHz); must be ≥16 and a multiple of 16.
- clk  in  1  system clock (50 MHz on board).
- reset  in  1  synchronous, active-high.
- sevenSegOne  in  8  code for the leftmost digit; bit0..6 = a..g, bit7 = dp, active-low.
- sevenSegTwo / sevenSegThree / sevenSegFour  in  8 each  codes for digits 2–4, same encoding.
- update  in  1  one-cycle strobe; captures all four inputs into the pending buffer.
- busy  out  1  high while a captured update has not yet been committed.
- updateAck  out  1  one-cycle pulse on the cycle the pending buffer is committed to the display.
- frameStart  out  1  one-cycle pulse when the scan wraps to digit 0.
- seg  out  8  cathode drive, active-low, same bit order as the inputs.
- an  out  4  anode drive, active-low; an[3] = leftmost digit.
- brightness  in  4  present only with SEVSEG_BRIGHTNESS_EN; 15 = full on.

## Operation
- Divider `cnt` counts 0..REFRESH_DIV-1. The slot-end tick is cnt==REFRESH_DIV-1. Digit index `idx` (2 bits) advances on the tick and wraps 3→0.
- Digit mapping: idx0→an=4'b0111 with display reg 0 (One); idx1→4'b1011 (Two); idx2→4'b1101 (Three); idx3→4'b1110 (Four).
- Buffers: pending[4] and display[4], each 8 bits.
  - `update` copies the four inputs to pending and sets busy.
  - A second update while busy overwrites pending; last one wins.
- Commit happens on the tick with idx==3 and busy=1: display←pending, busy←0, updateAck pulses.
  - If `update` is high in that same cycle, the inputs present that cycle are committed directly and busy stays 0.
- The display buffer is never changed mid-frame.
- seg, an, frameStart and updateAck are registered.

## Timing
- Reset values: an=4'b1111, seg=8'hFF, busy=0, updateAck=0, frameStart=0; cnt=0, idx=0; all pending and display regs 8'hFF (blank).
- First clock edge with reset low: an=4'b0111, seg=display[0].
- Outputs reflect the idx/cnt state of the previous cycle (one-cycle latency).
- Each digit is active for exactly REFRESH_DIV cycles. A frame is 4·REFRESH_DIV cycles.
- frameStart and updateAck assert on the same edge at which an switches to 4'b0111 after a commit.
- Worst-case update-to-display latency is 4·REFRESH_DIV+1 cycles.
- Reset asserted mid-frame: all state returns to reset values on the next edge and pending data is discarded.

## Configuration
- SEVSEG_BRIGHTNESS_EN defined:
  - The `brightness` port exists and is sampled at each slot start.
  - The anode is active only while cnt < (brightness+1)·(REFRESH_DIV/16); otherwise an=4'b1111.
  - seg stays driven for the whole slot.
- SEVSEG_BRIGHTNESS_EN undefined: the port is absent and the anode is active for the full slot.

## Structure
- Package seven_seg_pkg holds:
  - the blank code 8'hFF;
  - the four anode patterns indexed by idx;
  - the digit count (4);
  - the segment bit-position constants shared with the ASCII converters.
- Sub-module refresh_prescaler (parameter REFRESH_DIV): outputs cnt and a one-cycle tick. seven_seg_scan instantiates it once.

## Test plan
All scenarios use REFRESH_DIV=16.
- Reset, then run 64 cycles with no update -> seg=8'hFF throughout; an steps 0111,1011,1101,1110 every 16 cycles; frameStart pulses every 64 cycles.
- update with One..Four = 8'hC0, 8'hF9, 8'hA4, 8'hB0 mid-frame -> busy=1 until the next idx3 tick; updateAck and frameStart coincide; the next frame shows C0/F9/A4/B0 on an=0111/1011/1101/1110.
- Two updates in one frame (8'h88 ×4, then 8'h83 ×4) -> only 8'h83 is ever displayed; exactly one updateAck.
- update asserted exactly on the idx3 tick cycle -> that data is displayed in the next frame; busy never rises.
- Reset asserted mid-slot with busy=1 -> next edge: an=4'b1111, seg=8'hFF, busy=0; the pending data never appears.
- With SEVSEG_BRIGHTNESS_EN and brightness=3 -> each slot has an active for 4 cycles, then 4'b1111 for 12; brightness=15 -> active for all 16.
